filtro_dht22: RTL and testbench

FILTRO_DHT22 -- requirements
Module: filtro_dht22

---
 rtl/filtro_dht22.sv | 189 ++++++++++++++++++
 tb/tb_filtro_dht22.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/filtro_dht22.sv
// rtl/filtro_dht22.sv - DHT22 frame validator with 4-sample moving average and stale-data flag
//
// Ports:
//   clk             system clock, rising edge
//   reset_n         asynchronous active-low reset
//   umidade_in      humidity, tenths of %RH, unsigned
//   temperatura_in  temperature, tenths of degC, sign-magnitude (bit15 = sign)
//   dados_prontos   frame-ready level; a rising edge marks a new frame
//   checksum_ok     frame checksum status, valid with dados_prontos
//   umidade_out     averaged humidity, same format as umidade_in
//   temperatura_out averaged temperature, same format as temperatura_in
//   amostra_valida  at least one frame accepted since reset
//   nova_amostra    one-cycle pulse when the outputs update
//   dados_velhos    no accepted frame for STALE_CYCLES cycles
//   contador_erros  saturating count of rejected frames
module filtro_dht22 #(
    parameter int STALE_CYCLES = 300_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] umidade_in,
    input  logic [15:0] temperatura_in,
    input  logic        dados_prontos,
    input  logic        checksum_ok,
    output logic [15:0] umidade_out,
    output logic [15:0] temperatura_out,
    output logic        amostra_valida,
    output logic        nova_amostra,
    output logic        dados_velhos,
    output logic [7:0]  contador_erros
);

    localparam int CW = $clog2(STALE_CYCLES + 1);
    localparam logic [CW-1:0] STALE_MAX = CW'(STALE_CYCLES);

    typedef enum logic [1:0] {OCIOSO, VALIDA, ACUMULA, PUBLICA} estado_t;

    estado_t        estado;
    estado_t        proximo;
    logic           prontos_q;
    logic           borda;
    logic [15:0]    cap_u;
    logic [15:0]    cap_t;
    logic           cap_ok;
    logic           aceito;
    logic [11:0]    t_mag;
    logic [11:0]    temp_nova;
    logic [9:0]     hist_u [4];
    logic [11:0]    hist_t [4];
    logic           preload;
    logic [11:0]    soma_u;
    logic [13:0]    soma_t;
    logic [13:0]    mag_t;
    logic [15:0]    temp_pub;
    logic [CW-1:0]  idade;

    assign borda = dados_prontos & ~prontos_q;

    // Range check on the captured frame; -0 (0x8000) is a legal reading.
    always_comb begin
        aceito = cap_ok && (cap_u <= 16'd1000) &&
                 (cap_t[15] ? (cap_t[14:0] <= 15'd400) : (cap_t[14:0] <= 15'd1250));
    end

    // An accepted magnitude is at most 1250, so bits 14:11 are always zero here.
    always_comb begin
        t_mag     = {1'b0, cap_t[10:0]};
        temp_nova = cap_t[15] ? (12'd0 - t_mag) : t_mag;
    end

    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO:  if (borda) proximo = VALIDA;
            VALIDA:  proximo = aceito ? ACUMULA : OCIOSO;
            ACUMULA: proximo = PUBLICA;
            PUBLICA: proximo = OCIOSO;
            default: proximo = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo;
        end
    end

    // Edge register runs in every state; edges seen outside OCIOSO are simply dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prontos_q <= 1'b0;
            cap_u     <= '0;
            cap_t     <= '0;
            cap_ok    <= 1'b0;
        end else begin
            prontos_q <= dados_prontos;
            if (estado == OCIOSO && borda) begin
                cap_u  <= umidade_in;
                cap_t  <= temperatura_in;
                cap_ok <= checksum_ok;
            end
        end
    end

    // History: index 0 is newest. The first frame after reset fills all four
    // slots so the average starts at the first reading instead of ramping from 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            preload <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                hist_u[i] <= '0;
                hist_t[i] <= '0;
            end
        end else if (estado == VALIDA && aceito) begin
            preload <= 1'b1;
            if (!preload) begin
                for (int i = 0; i < 4; i++) begin
                    hist_u[i] <= cap_u[9:0];
                    hist_t[i] <= temp_nova;
                end
            end else begin
                for (int i = 3; i > 0; i--) begin
                    hist_u[i] <= hist_u[i-1];
                    hist_t[i] <= hist_t[i-1];
                end
                hist_u[0] <= cap_u[9:0];
                hist_t[0] <= temp_nova;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            soma_u <= '0;
            soma_t <= '0;
        end else if (estado == ACUMULA) begin
            soma_u <= 12'(hist_u[0]) + 12'(hist_u[1]) + 12'(hist_u[2]) + 12'(hist_u[3]);
            soma_t <= {{2{hist_t[0][11]}}, hist_t[0]} + {{2{hist_t[1][11]}}, hist_t[1]} +
                      {{2{hist_t[2][11]}}, hist_t[2]} + {{2{hist_t[3][11]}}, hist_t[3]};
        end
    end

    // Divide the magnitude, not the signed sum, so the result truncates toward
    // zero; a zero quotient always comes out as +0.
    always_comb begin
        mag_t = soma_t[13] ? (14'd0 - soma_t) : soma_t;
        if (mag_t[13:2] == 12'd0) begin
            temp_pub = 16'h0000;
        end else begin
            temp_pub = {soma_t[13], 3'b000, mag_t[13:2]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            umidade_out     <= '0;
            temperatura_out <= '0;
            amostra_valida  <= 1'b0;
            nova_amostra    <= 1'b0;
            contador_erros  <= '0;
        end else begin
            nova_amostra <= (estado == PUBLICA);
            if (estado == PUBLICA) begin
                umidade_out     <= {6'b000000, soma_u[11:2]};
                temperatura_out <= temp_pub;
                amostra_valida  <= 1'b1;
            end
            if (estado == VALIDA && !aceito && contador_erros != 8'hFF) begin
                contador_erros <= contador_erros + 8'd1;
            end
        end
    end

    // Cycles since the last publication (or reset), saturating at the threshold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idade <= '0;
        end else if (estado == PUBLICA) begin
            idade <= '0;
        end else if (idade != STALE_MAX) begin
            idade <= idade + 1'b1;
        end
    end

    assign dados_velhos = (idade == STALE_MAX);

endmodule

// File: tb/tb_filtro_dht22.sv
// tb/tb_filtro_dht22.sv - self-checking bench for filtro_dht22
module tb_filtro_dht22;

    localparam int STALE = 100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] umidade_in;
    logic [15:0] temperatura_in;
    logic        dados_prontos;
    logic        checksum_ok;
    logic [15:0] umidade_out;
    logic [15:0] temperatura_out;
    logic        amostra_valida;
    logic        nova_amostra;
    logic        dados_velhos;
    logic [7:0]  contador_erros;

    always #5 clk = ~clk;

    filtro_dht22 #(.STALE_CYCLES(STALE)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .umidade_in      (umidade_in),
        .temperatura_in  (temperatura_in),
        .dados_prontos   (dados_prontos),
        .checksum_ok     (checksum_ok),
        .umidade_out     (umidade_out),
        .temperatura_out (temperatura_out),
        .amostra_valida  (amostra_valida),
        .nova_amostra    (nova_amostra),
        .dados_velhos    (dados_velhos),
        .contador_erros  (contador_erros)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_u = '0;
    logic [15:0] exp_t = '0;
    logic        exp_valid = 1'b0;
    logic        exp_nova = 1'b0;
    logic [7:0]  exp_err = '0;
    int          cyc = 0;
    int          base = 0;
    int          hu [4];
    int          ht [4];
    bit          mpre = 1'b0;

    always @(posedge clk) if (reset_n) cyc <= cyc + 1;

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nome, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        check("umidade_out", umidade_out, exp_u);
        check("temperatura_out", temperatura_out, exp_t);
        check("amostra_valida", amostra_valida, exp_valid);
        check("nova_amostra", nova_amostra, exp_nova);
        check("contador_erros", contador_erros, exp_err);
        check("dados_velhos", dados_velhos, (cyc - base) >= STALE);
    end

    function automatic bit aceita(input logic [15:0] u, input logic [15:0] t, input logic ok);
        int mag;
        mag = int'(t[14:0]);
        return ok && (int'(u) <= 1000) && (t[15] ? (mag <= 400) : (mag <= 1250));
    endfunction

    task automatic model_publish(input logic [15:0] u, input logic [15:0] t);
        int tv, su, st, mag;
        tv = t[15] ? -int'(t[14:0]) : int'(t[14:0]);
        if (!mpre) begin
            for (int i = 0; i < 4; i++) begin
                hu[i] = int'(u);
                ht[i] = tv;
            end
            mpre = 1'b1;
        end else begin
            for (int i = 3; i > 0; i--) begin
                hu[i] = hu[i-1];
                ht[i] = ht[i-1];
            end
            hu[0] = int'(u);
            ht[0] = tv;
        end
        su = hu[0] + hu[1] + hu[2] + hu[3];
        st = ht[0] + ht[1] + ht[2] + ht[3];
        mag = ((st < 0) ? -st : st) / 4;
        exp_u = 16'(su / 4);
        if (mag == 0) exp_t = 16'h0000;
        else exp_t = 16'(mag) | ((st < 0) ? 16'h8000 : 16'h0000);
        exp_valid = 1'b1;
        exp_nova = 1'b1;
        base = cyc;
    endtask

    task automatic frame(input logic [15:0] u, input logic [15:0] t, input logic ok,
                         input bit glitch = 1'b0);
        bit acc;
        acc = aceita(u, t, ok);
        @(negedge clk);
        umidade_in = u;
        temperatura_in = t;
        checksum_ok = ok;
        dados_prontos = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dados_prontos = 1'b0;
        umidade_in = ~u;
        temperatura_in = ~t;
        checksum_ok = ~ok;
        @(posedge clk);
        #1;
        if (!acc && exp_err != 8'hFF) exp_err = exp_err + 8'd1;
        if (glitch) begin
            @(negedge clk);
            dados_prontos = 1'b1;
            checksum_ok = 1'b0;
        end
        @(posedge clk);
        if (glitch) begin
            @(negedge clk);
            dados_prontos = 1'b0;
        end
        @(posedge clk);
        #1;
        if (acc) model_publish(u, t);
        @(posedge clk);
        #1;
        exp_nova = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        umidade_in = '0;
        temperatura_in = '0;
        dados_prontos = 1'b0;
        checksum_ok = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        base = cyc;
        @(negedge clk);
        check("reset umidade", umidade_out, 16'h0000);
        check("reset valida", amostra_valida, 1'b0);

        frame(16'h0271, 16'h00FA, 1'b1);
        check("first umidade", umidade_out, 16'h0271);
        check("first temperatura", temperatura_out, 16'h00FA);
        check("first valida", amostra_valida, 1'b1);

        frame(16'h0271, 16'h0104, 1'b1);
        check("avg 25.2", temperatura_out, 16'h00FC);

        frame(16'h0300, 16'h0104, 1'b1, 1'b1);
        check("ignored edge err", contador_erros, 8'd0);

        frame(16'h0271, 16'h00FA, 1'b0);
        check("err checksum", contador_erros, 8'd1);
        frame(16'h03E9, 16'h00FA, 1'b1);
        check("err umid 1001", contador_erros, 8'd2);
        frame(16'h0271, 16'h8191, 1'b1);
        check("err temp -40.1", contador_erros, 8'd3);
        frame(16'h0200, 16'h04E3, 1'b1);
        check("err temp 125.1", contador_erros, 8'd4);
        frame(16'd1000, 16'h8190, 1'b1);
        frame(16'd1000, 16'h04E2, 1'b1);

        repeat (98) @(posedge clk);
        #1;
        check("stale at 99", dados_velhos, 1'b0);
        @(posedge clk);
        #1;
        check("stale at 100", dados_velhos, 1'b1);
        check("valid while stale", amostra_valida, 1'b1);
        frame(16'd500, 16'd200, 1'b1);
        check("stale cleared", dados_velhos, 1'b0);

        for (int i = 0; i < 260; i++) frame(16'd100, 16'd100, 1'b0);
        check("err saturated", contador_erros, 8'd255);

        @(negedge clk);
        umidade_in = 16'd500;
        temperatura_in = 16'd300;
        checksum_ok = 1'b1;
        dados_prontos = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dados_prontos = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        exp_u = '0;
        exp_t = '0;
        exp_valid = 1'b0;
        exp_nova = 1'b0;
        exp_err = '0;
        mpre = 1'b0;
        base = cyc;
        check("async umidade", umidade_out, 16'h0000);
        check("async temperatura", temperatura_out, 16'h0000);
        check("async valida", amostra_valida, 1'b0);
        check("async erros", contador_erros, 8'd0);
        check("async velhos", dados_velhos, 1'b0);
        repeat (4) @(negedge clk);
        check("no pulse in reset", nova_amostra, 1'b0);
        reset_n = 1'b1;
        base = cyc;

        frame(16'd400, 16'h8005, 1'b1);
        check("preload -0.5", temperatura_out, 16'h8005);
        frame(16'd400, 16'h0002, 1'b1);
        check("avg -13/4", temperatura_out, 16'h8003);
        frame(16'd400, 16'h0000, 1'b1);
        check("avg -8/4", temperatura_out, 16'h8002);
        frame(16'd400, 16'h0000, 1'b1);
        check("avg -3/4 zero", temperatura_out, 16'h0000);
        frame(16'd400, 16'h8000, 1'b1);
        frame(16'd400, 16'h0000, 1'b1);
        check("all zero", temperatura_out, 16'h0000);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
